// File: rtl/result_byte_sender_pkg.sv
// result_byte_sender_pkg: shared state encodings and slice-count helper for the product sender
package result_byte_sender_pkg;
    typedef enum logic [1:0] {
        SND_IDLE    = 2'b00,
        SND_ARM     = 2'b01,
        SND_PRESENT = 2'b10,
        SND_HOLD    = 2'b11
    } snd_state_t;

    function automatic int slice_count(input int n, input int w);
        return (2 * n) / w;
    endfunction

    function automatic int idx_width(input int n, input int w);
        return slice_count(n, w) > 1 ? $clog2(slice_count(n, w)) : 1;
    endfunction
endpackage

// File: rtl/result_byte_sender_if.sv
// result_byte_sender_if: capture strobe, step button and slice output bundle
interface result_byte_sender_if
    import result_byte_sender_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 8
);
    localparam int IW = idx_width(N, W);
    logic            ldRes;
    logic [2*N-1:0]  product;
    logic            ovIn;
    logic            getP;
    logic [W-1:0]    dataOut;
    logic [IW-1:0]   byteIdx;
    logic            valid;
    logic            busy;
    logic            ovOut;
    logic            done;
    modport master (
        output ldRes, product, ovIn, getP,
        input  dataOut, byteIdx, valid, busy, ovOut, done
    );
    modport slave (
        input  ldRes, product, ovIn, getP,
        output dataOut, byteIdx, valid, busy, ovOut, done
    );
endinterface

// File: rtl/result_byte_sender_counter.sv
// result_slice_counter: mod-S slice counter with enable, clear and carry-out
module result_slice_counter #(
    parameter int S  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [IW-1:0] cnt,
    output logic          co
);
    assign co = en && cnt == IW'(S - 1);
    always_ff @(posedge clk)
        if (!rst || clr || co) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/result_byte_sender.sv
// result_byte_sender: captures the 2N-bit product and steps it out W bits per getP press/release
module result_byte_sender
    import result_byte_sender_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 8
) (
    input logic clk,
    input logic rst,
    result_byte_sender_if.slave bus
);
    localparam int S  = slice_count(N, W);
    localparam int IW = idx_width(N, W);
    snd_state_t     state;
    logic [2*N-1:0] shadow;
    logic [IW-1:0]  cnt;
    logic           co;
    logic           valid;
    result_slice_counter #(.S(S), .IW(IW)) u_cnt (
        .clk(clk),
        .rst(rst),
        .en (state == SND_HOLD && bus.getP),
        .clr(state == SND_IDLE && bus.ldRes),
        .cnt(cnt),
        .co (co)
    );
    assign valid       = state == SND_PRESENT || state == SND_HOLD;
    assign bus.valid   = valid;
    assign bus.busy    = state != SND_IDLE;
    assign bus.byteIdx = valid ? cnt : '0;
    assign bus.dataOut = valid ? shadow[cnt*W +: W] : '0;
    // a press already held at capture parks in Arm so it cannot acknowledge slice 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= SND_IDLE;
            shadow    <= '0;
            bus.ovOut <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                SND_IDLE:
                    if (bus.ldRes) begin
                        shadow    <= bus.product;
                        bus.ovOut <= bus.ovIn;
                        state     <= bus.getP ? SND_PRESENT : SND_ARM;
                    end
                SND_ARM:     state <= bus.getP ? SND_PRESENT : SND_ARM;
                SND_PRESENT: state <= bus.getP ? SND_PRESENT : SND_HOLD;
                SND_HOLD:
                    if (bus.getP) begin
                        state    <= co ? SND_IDLE : SND_PRESENT;
                        bus.done <= co;
                    end
                default:     state <= SND_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_byte_sender.sv
// tb_result_byte_sender: directed checks of capture, stepping, stale/long press, ignored load and reset abort
module tb_result_byte_sender;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad = 0;
    result_byte_sender_if #(.N(16), .W(8)) bus ();
    result_byte_sender #(.N(16), .W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] d, input logic [1:0] i,
                           input logic v, input logic b, input logic o, input logic dn);
        chk({tag, ".dataOut"}, 32'(bus.dataOut), 32'(d));
        chk({tag, ".byteIdx"}, 32'(bus.byteIdx), 32'(i));
        chk({tag, ".valid"}, 32'(bus.valid), 32'(v));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
        chk({tag, ".ovOut"}, 32'(bus.ovOut), 32'(o));
        chk({tag, ".done"}, 32'(bus.done), 32'(dn));
    endtask

    task automatic load(input logic [31:0] p, input logic ov);
        bus.ldRes = 1'b1;
        bus.product = p;
        bus.ovIn = ov;
        cyc(1);
        bus.ldRes = 1'b0;
    endtask

    task automatic press_release();
        bus.getP = 1'b0;
        cyc(1);
        bus.getP = 1'b1;
        cyc(1);
    endtask

    initial begin
        bus.ldRes = 1'b0;
        bus.product = '0;
        bus.ovIn = 1'b0;
        bus.getP = 1'b1;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk_all("reset", 8'h00, 2'd0, 0, 0, 0, 0);
        press_release();
        chk_all("idle_toggle", 8'h00, 2'd0, 0, 0, 0, 0);

        load(32'h12345678, 1'b1);
        chk_all("basic_s0", 8'h78, 2'd0, 1, 1, 1, 0);
        bus.getP = 1'b0;
        cyc(1);
        chk_all("basic_s0_press", 8'h78, 2'd0, 1, 1, 1, 0);
        bus.getP = 1'b1;
        cyc(1);
        chk_all("basic_s1", 8'h56, 2'd1, 1, 1, 1, 0);
        press_release();
        chk_all("basic_s2", 8'h34, 2'd2, 1, 1, 1, 0);
        press_release();
        chk_all("basic_s3", 8'h12, 2'd3, 1, 1, 1, 0);
        press_release();
        chk_all("basic_done", 8'h00, 2'd0, 0, 0, 1, 1);
        cyc(1);
        chk_all("basic_idle", 8'h00, 2'd0, 0, 0, 1, 0);

        bus.getP = 1'b0;
        load(32'hDEADBEEF, 1'b0);
        chk_all("stale_arm", 8'h00, 2'd0, 0, 1, 0, 0);
        cyc(3);
        chk_all("stale_arm_hold", 8'h00, 2'd0, 0, 1, 0, 0);
        bus.getP = 1'b1;
        cyc(1);
        chk_all("stale_s0", 8'hEF, 2'd0, 1, 1, 0, 0);
        press_release();
        chk("stale_s1", 32'(bus.dataOut), 32'hBE);
        press_release();
        press_release();
        chk("stale_s3", 32'(bus.dataOut), 32'hDE);
        press_release();
        chk("stale_done", 32'(bus.done), 32'd1);

        load(32'hA1B2C3D4, 1'b0);
        press_release();
        chk_all("long_s1", 8'hC3, 2'd1, 1, 1, 0, 0);
        bus.getP = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cyc(1);
            chk("long_data", 32'(bus.dataOut), 32'hC3);
            chk("long_idx", 32'(bus.byteIdx), 32'd1);
        end
        bus.getP = 1'b1;
        cyc(1);
        chk_all("long_s2", 8'hB2, 2'd2, 1, 1, 0, 0);
        press_release();
        press_release();
        chk("long_done", 32'(bus.done), 32'd1);

        load(32'h11223344, 1'b1);
        press_release();
        press_release();
        chk_all("ign_s2", 8'h22, 2'd2, 1, 1, 1, 0);
        load(32'hFFFFFFFF, 1'b0);
        chk_all("ign_after_ld", 8'h22, 2'd2, 1, 1, 1, 0);
        press_release();
        chk_all("ign_s3", 8'h11, 2'd3, 1, 1, 1, 0);
        press_release();
        chk_all("ign_done", 8'h00, 2'd0, 0, 0, 1, 1);

        load(32'h55667788, 1'b1);
        press_release();
        press_release();
        bus.getP = 1'b0;
        cyc(1);
        chk_all("rst_hold_s2", 8'h66, 2'd2, 1, 1, 1, 0);
        rst = 1'b0;
        cyc(1);
        chk_all("rst_mid", 8'h00, 2'd0, 0, 0, 0, 0);
        rst = 1'b1;
        bus.getP = 1'b1;
        cyc(1);
        chk_all("rst_after", 8'h00, 2'd0, 0, 0, 0, 0);
        load(32'h00000001, 1'b0);
        chk_all("fresh_s0", 8'h01, 2'd0, 1, 1, 0, 0);
        press_release();
        chk_all("fresh_s1", 8'h00, 2'd1, 1, 1, 0, 0);
        press_release();
        chk_all("fresh_s2", 8'h00, 2'd2, 1, 1, 0, 0);
        press_release();
        chk_all("fresh_s3", 8'h00, 2'd3, 1, 1, 0, 0);
        press_release();
        chk_all("fresh_done", 8'h00, 2'd0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/result_byte_sender.md
# result_byte_sender

Transmit-side counterpart of the operand-entry front end of the radix-4 multiplier. It captures the finished 2N-bit product plus overflow flag when the datapath signals completion. It then presents the product one W-bit slice at a time on the board output bus, LSB slice first. Each slice is advanced by a press/release cycle of the active-low `getP` button, mirroring the `getA`/`getX` entry handshake.

## Interface
Parameters:
- `N`, 16, multiplier operand width; product width is 2N.
- `W`, 8, output slice width; 2N must be an exact multiple of W.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous reset, active-low: sampled on `clk`, state cleared when `rst`=0.
- `ldRes`  in  1  one-cycle strobe from the multiplier controller: product is valid this cycle.
- `product`  in  2N  finished product, sampled only when `ldRes`=1 in Idle.
- `ovIn`  in  1  overflow flag, sampled with `product`.
- `getP`  in  1  active-low step button: 0 = pressed, 1 = released.
- `dataOut`  out  W  current product slice; 0 when not valid.
- `byteIdx`  out  $clog2(2N/W)  index of the slice on `dataOut`, 0 = LSB slice.
- `valid`  out  1  `dataOut` holds a slice.
- `busy`  out  1  a product is captured and not fully sent.
- `ovOut`  out  1  captured overflow flag; held until the next capture or reset.
- `done`  out  1  one-cycle pulse after the last slice is released.

## Operation
- Let S = 2N/W (4 at defaults).
- States: Idle, Arm, Present, Hold.
- Idle:
  - `ldRes`=1 → latch `product` into the shadow register, latch `ovIn` into `ovOut`, clear the slice counter.
  - Go to Arm if `getP`=0, else to Present.
  - `ldRes`=0 → stay.
- Arm: `getP`=1 → Present; else stay. This guarantees no stale press acknowledges slice 0.
- Present: `getP`=0 → Hold; else stay.
- Hold:
  - `getP`=1 and counter = S−1 → Idle, pulse `done`.
  - `getP`=1 otherwise → increment counter, go to Present.
  - `getP`=0 → stay.
- `dataOut` = shadow[byteIdx*W +: W] in Present and Hold; 0 in Idle and Arm.
- `valid` = 1 in Present and Hold only.
- `busy` = 1 in Arm, Present and Hold.
- `ldRes` outside Idle is ignored: the shadow register and `ovOut` are unchanged.
- The counter wraps to 0 on exit from Hold at S−1. `byteIdx` reads 0 in Idle.
- No arithmetic beyond the counter; the slice select is a pure mux.

## Timing
- Reset: `rst`=0 at edge t → from t+1, state Idle, shadow=0. All outputs read 0: `dataOut`, `byteIdx`, `valid`, `busy`, `ovOut`, `done`.
- Reset mid-transfer aborts the transfer, emits no `done`, and discards the captured product.
- Capture latency: `ldRes` at edge t with `getP`=1 → `valid`=1, `byteIdx`=0, slice 0 on `dataOut` after edge t.
- Advance: `getP` low at edge t1, high at edge t2 → after t2, `byteIdx` increments and `dataOut` changes.
- `dataOut` is stable through the whole press.
- `done` is high for exactly the cycle after the edge that releases slice S−1; `busy` is 0 in that same cycle.
- A new `ldRes` may be accepted in the `done` cycle.
- All outputs are registered or decoded from registered state only; no combinational path from `getP` or `ldRes` to any output.
- `getP` is assumed debounced and synchronized upstream.

## Structure
- Shared package holds:
  - state encodings `SND_IDLE`=2'b00, `SND_ARM`=2'b01, `SND_PRESENT`=2'b10, `SND_HOLD`=2'b11;
  - a function returning the slice count S from N and W.
- One sub-module, `result_slice_counter`:
  - mod-S counter with `en`, `clr` and carry-out;
  - synchronous active-low reset;
  - counterpart of the counter used by the multiplier controller.
- The FSM and shadow register stay in `result_byte_sender`.

## Test plan
- Reset/idle: hold `rst`=0 for 2 cycles, then release → all outputs 0; `getP` toggling in Idle has no effect.
- Basic send (N=16, W=8): `ldRes` with `product`=0x12345678, `ovIn`=1, `getP`=1.
  - Required: `dataOut`=0x78, `byteIdx`=0, `ovOut`=1.
  - Three press/release cycles yield 0x56, 0x34, 0x12.
  - Fourth release → one-cycle `done`, then Idle with `dataOut`=0, `ovOut` still 1.
- Stale press: `ldRes` with `product`=0xDEADBEEF while `getP`=0 → state Arm, `valid`=0. Release → `dataOut`=0xEF, `byteIdx`=0; no slice skipped.
- Long press: hold `getP`=0 for 50 cycles on slice 1 of 0xA1B2C3D4 → `dataOut` stays 0xC3 and `byteIdx` stays 1 throughout; advances only on release.
- Ignored load: during slice 2 of 0x11223344, pulse `ldRes` with `product`=0xFFFFFFFF → remaining slices 0x22, 0x11; `ovOut` unchanged.
- Mid-transfer reset: `rst`=0 during Hold on slice 2 → next cycle all outputs 0, no `done`. A fresh `ldRes` with 0x00000001 then sends 0x01, 0x00, 0x00, 0x00.
